// File: rtl/word_loader.sv
// word_loader: splits a valid/ready byte stream into words on DELIM or newline,
// writes each word null-terminated into the matcher's input SRAM from address 0,
// pulses the matcher start, waits for done/found and hands back one result per
// word before re-arming the matcher.
// Optional build macro: WORD_LOADER_LOWERCASE_EN folds 'A'-'Z' to lower case on
// write (length and delimiter decisions always use the original byte).
module word_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DELIM = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  match_cs,
    output logic                  match_rst_n,
    input  logic                  match_done,
    input  logic                  match_found,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_found,
    output logic                  res_ovf,
    output logic [ADDR_WIDTH-1:0] res_len
);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_DISCARD = 3'd1,
        S_TERM    = 3'd2,
        S_START   = 3'd3,
        S_WAIT    = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LEN_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] LEN_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] LEN_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] NEWLINE  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] NUL      = {DATA_WIDTH{1'b0}};

`ifdef WORD_LOADER_LOWERCASE_EN
    // Fold an upper-case ASCII letter to lower case; anything else passes through.
    function automatic logic [DATA_WIDTH-1:0] to_lower(input logic [DATA_WIDTH-1:0] b);
        if ((b >= DATA_WIDTH'(8'h41)) && (b <= DATA_WIDTH'(8'h5A))) begin
            to_lower = b + DATA_WIDTH'(8'h20);
        end else begin
            to_lower = b;
        end
    endfunction
`endif

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] len_r, len_s;
    logic                  in_ready_r, in_ready_s;
    logic                  wr_en_r, wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_r, wr_data_s;
    logic                  match_cs_r, match_cs_s;
    logic                  match_rst_n_r, match_rst_n_s;
    logic                  res_valid_r, res_valid_s;
    logic                  res_found_r, res_found_s;
    logic                  res_ovf_r, res_ovf_s;
    logic [ADDR_WIDTH-1:0] res_len_r, res_len_s;
    logic                  accept_s;
    logic                  is_delim_s;
    logic [DATA_WIDTH-1:0] wr_char_s;

    assign accept_s   = in_valid && in_ready_r;
    assign is_delim_s = (in_data == DELIM) || (in_data == NEWLINE);

`ifdef WORD_LOADER_LOWERCASE_EN
    assign wr_char_s = to_lower(in_data);
`else
    assign wr_char_s = in_data;
`endif

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s       = state_r;
        len_s         = len_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = wr_addr_r;
        wr_data_s     = wr_data_r;
        match_cs_s    = 1'b0;
        match_rst_n_s = 1'b1;
        res_valid_s   = res_valid_r;
        res_found_s   = res_found_r;
        res_ovf_s     = res_ovf_r;
        res_len_s     = res_len_r;
        case (state_r)
            S_FILL: begin
                if (accept_s) begin
                    if (is_delim_s) begin
                        if (len_r != LEN_ZERO) begin
                            // Terminator goes out the cycle after the delimiter.
                            wr_en_s   = 1'b1;
                            wr_addr_s = len_r;
                            wr_data_s = NUL;
                            state_s   = S_TERM;
                        end else begin
                            state_s = S_FILL;
                        end
                    end else if (len_r == LEN_MAX) begin
                        // No room left for the terminator slot: give up on this word.
                        res_ovf_s = 1'b1;
                        state_s   = S_DISCARD;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = len_r;
                        wr_data_s = wr_char_s;
                        len_s     = len_r + LEN_ONE;
                    end
                end else begin
                    state_s = S_FILL;
                end
            end
            S_DISCARD: begin
                if (accept_s && is_delim_s) begin
                    res_valid_s = 1'b1;
                    res_found_s = 1'b0;
                    res_len_s   = len_r;
                    state_s     = S_REPORT;
                end else begin
                    state_s = S_DISCARD;
                end
            end
            S_TERM: begin
                match_cs_s = 1'b1;
                state_s    = S_START;
            end
            S_START: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (match_done) begin
                    res_valid_s = 1'b1;
                    res_found_s = match_found;
                    res_len_s   = len_r;
                    state_s     = S_REPORT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    // Handshake: pulse the matcher re-arm and start a fresh word.
                    res_valid_s   = 1'b0;
                    res_found_s   = 1'b0;
                    res_ovf_s     = 1'b0;
                    res_len_s     = LEN_ZERO;
                    len_s         = LEN_ZERO;
                    match_rst_n_s = 1'b0;
                    state_s       = S_FILL;
                end else begin
                    state_s = S_REPORT;
                end
            end
            default: begin
                state_s = S_FILL;
            end
        endcase
        in_ready_s = (state_s == S_FILL) || (state_s == S_DISCARD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_FILL;
            len_r         <= LEN_ZERO;
            in_ready_r    <= 1'b1;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= LEN_ZERO;
            wr_data_r     <= NUL;
            match_cs_r    <= 1'b0;
            match_rst_n_r <= 1'b0;
            res_valid_r   <= 1'b0;
            res_found_r   <= 1'b0;
            res_ovf_r     <= 1'b0;
            res_len_r     <= LEN_ZERO;
        end else begin
            state_r       <= state_s;
            len_r         <= len_s;
            in_ready_r    <= in_ready_s;
            wr_en_r       <= wr_en_s;
            wr_addr_r     <= wr_addr_s;
            wr_data_r     <= wr_data_s;
            match_cs_r    <= match_cs_s;
            match_rst_n_r <= match_rst_n_s;
            res_valid_r   <= res_valid_s;
            res_found_r   <= res_found_s;
            res_ovf_r     <= res_ovf_s;
            res_len_r     <= res_len_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign wr_en       = wr_en_r;
    assign wr_addr     = wr_addr_r;
    assign wr_data     = wr_data_r;
    assign match_cs    = match_cs_r;
    assign match_rst_n = match_rst_n_r;
    assign res_valid   = res_valid_r;
    assign res_found   = res_found_r;
    assign res_ovf     = res_ovf_r;
    assign res_len     = res_len_r;

endmodule
